huffman_encoder: RTL
====================

HUFFMAN_ENCODER -- requirements
Module: huffman_encoder

Interface
REQ-001 SHALL provide port: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL provide port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL provide port: sym_valid  input  1  upstream asserts when sym holds a symbol to encode.
REQ-004 SHALL provide port: sym  input  3  symbol index; valid values 1..6; 0 and 7 are invalid.
REQ-005 SHALL provide port: sym_ready  output  1  block accepts sym this cycle when high.
REQ-006 SHALL provide port: out_bit  output  1  serial code bit, MSB of codeword first.
REQ-007 SHALL provide port: out_valid  output  1  out_bit carries a codeword bit this cycle.
REQ-008 SHALL provide port: code_last  output  1  high with the final bit of each codeword.
REQ-009 SHALL provide port (HUFFMAN_ENC_ERR_EN only): sym_err  output  1  one-cycle pulse for an accepted invalid symbol.

Function
REQ-010 SHALL use the fixed codebook, transmitted left to right: 1=00, 2=01, 3=10, 4=110, 5=111000, 6=111001.
REQ-011 SHALL implement two states: IDLE (no code in flight) and SHIFT (emitting bits), plus a shift register and a 3-bit remaining-bit counter.
REQ-012 SHALL accept a symbol on the rising edge where sym_valid=1 and sym_ready=1; no other edge samples sym.
REQ-013 SHALL drive sym_ready=1 in IDLE, and in SHIFT only on the cycle code_last=1; 0 otherwise.
REQ-014 SHALL drive the first codeword bit on out_bit with out_valid=1 in the cycle after acceptance (latency 1), one bit per cycle, L cycles for an L-bit code.
REQ-015 SHALL assert code_last only on the Lth bit cycle of each codeword.
REQ-016 SHALL, on acceptance concurrent with code_last, begin the new codeword in the very next cycle, with no idle gap between codewords.
REQ-017 SHALL return to IDLE after code_last when no symbol is accepted on that edge; out_valid=0, out_bit=0, code_last=0 in IDLE.
REQ-018 SHALL treat an accepted invalid symbol (0 or 7) as emitting zero bits: the state stays or becomes IDLE and out_valid=0 in the following cycle.
REQ-019 SHALL have no downstream backpressure; the bit stream is consumed unconditionally at one bit per cycle.
REQ-020 SHALL hold sym_valid-independent behaviour while in SHIFT: changes on sym/sym_valid have no effect until sym_ready=1.

Reset
REQ-021 SHALL, while rst=1 at a rising edge, enter IDLE and clear the shift register, counter, out_bit=0, out_valid=0, code_last=0, sym_err=0.
REQ-022 SHALL drive sym_ready=0 in any cycle where rst=1, and ignore sym_valid in those cycles.
REQ-023 SHALL abort a codeword in flight on reset, emitting no further bits of it; the next codeword starts clean after rst deasserts.

Configuration
REQ-024 SHALL, with macro HUFFMAN_ENC_ERR_EN defined, include port sym_err, pulsed high for exactly the one cycle after an invalid symbol is accepted.
REQ-025 SHALL, without HUFFMAN_ENC_ERR_EN, omit port sym_err and drop invalid symbols silently; all other behaviour is identical.

Verification
REQ-026 SHALL cover: accept sym=1 at edge T -> out_bit 0,0 at T+1,T+2, out_valid=1 for both, code_last=1 only at T+2, IDLE at T+3.
REQ-027 SHALL cover: sym=4 then sym=2 back-to-back (second accepted while code_last=1) -> continuous out_bit 1,1,0,0,1 over 5 cycles, code_last at bits 3 and 5.
REQ-028 SHALL cover: sym=5 then sym=6 -> 111000 then 111001, 12 consecutive valid bits; sym_ready=0 on all non-last SHIFT cycles.
REQ-029 SHALL cover: accept sym=7 with HUFFMAN_ENC_ERR_EN -> sym_err=1 at T+1 only, out_valid=0, sym_ready=1 at T+1.
REQ-030 SHALL cover: rst=1 during bit 3 of sym=6 -> next cycle out_valid=0, code_last=0, sym_ready=0 while rst=1; after release, sym=3 encodes as 1,0.
REQ-031 SHALL cover: sym_valid toggled with sym values 1..6 during SHIFT -> no effect on the in-flight codeword.

Source files
------------

// File: rtl/huffman_encoder.sv
// Fixed-codebook Huffman encoder, one serial bit per cycle, MSB first; HUFFMAN_ENC_ERR_EN adds sym_err.
// Latency 1 (first bit the cycle after acceptance); no downstream backpressure, sym_ready only in IDLE or on code_last.
module huffman_encoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       sym_valid,
    input  logic [2:0] sym,
    output logic       sym_ready,
    output logic       out_bit,
    output logic       out_valid,
    output logic       code_last
`ifdef HUFFMAN_ENC_ERR_EN
    ,
    output logic       sym_err
`endif
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [5:0] r_shift;
    logic [5:0] w_shift_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;

    logic [5:0] w_code;
    logic [2:0] w_len;
    logic       w_sym_ok;
    logic       w_accept;
    logic       w_last;

    // Codewords are left-aligned so the next bit to send is always r_shift[5].
    always_comb begin
        w_code   = 6'b000000;
        w_len    = 3'd0;
        w_sym_ok = 1'b1;
        case (sym)
            3'd1:    begin w_code = 6'b000000; w_len = 3'd2; end
            3'd2:    begin w_code = 6'b010000; w_len = 3'd2; end
            3'd3:    begin w_code = 6'b100000; w_len = 3'd2; end
            3'd4:    begin w_code = 6'b110000; w_len = 3'd3; end
            3'd5:    begin w_code = 6'b111000; w_len = 3'd6; end
            3'd6:    begin w_code = 6'b111001; w_len = 3'd6; end
            default: w_sym_ok = 1'b0;
        endcase
    end

    assign w_last    = (r_state == SHIFT) && (r_cnt == 3'd1);
    assign sym_ready = !rst && ((r_state == IDLE) || w_last);
    assign w_accept  = sym_valid && sym_ready;
    assign out_valid = (r_state == SHIFT);
    assign out_bit   = (r_state == SHIFT) && r_shift[5];
    assign code_last = w_last;

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept && w_sym_ok) begin
                    w_state_nxt = SHIFT;
                    w_shift_nxt = w_code;
                    w_cnt_nxt   = w_len;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    // Back-to-back codewords reload on the last bit with no gap.
                    if (w_accept && w_sym_ok) begin
                        w_shift_nxt = w_code;
                        w_cnt_nxt   = w_len;
                    end else begin
                        w_state_nxt = IDLE;
                        w_shift_nxt = 6'b000000;
                        w_cnt_nxt   = 3'd0;
                    end
                end else begin
                    w_shift_nxt = {r_shift[4:0], 1'b0};
                    w_cnt_nxt   = r_cnt - 3'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_shift_nxt = 6'b000000;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= 6'b000000;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

`ifdef HUFFMAN_ENC_ERR_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && !w_sym_ok;
        end
    end

    assign sym_err = r_err;
`endif

endmodule
